// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// uart_receiver : mid-bit sampling UART receiver with a valid/ack byte output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Revision 1.0
// ============================================================================
module uart_receiver #(
  parameter int COMP_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rec_en,
  input  logic [COMP_W-1:0] comp,
  input  logic [1:0]        stop_sel,
  input  logic              uart_rx,
`ifdef UART_RX_PARITY_EN
  input  logic              par_en,
  input  logic              par_odd,
  output logic              parity_err,
`endif
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              frame_err,
  output logic              overrun_err
);

  typedef enum logic [2:0] {
    IDLE_s,
    START_s,
    RECEIVE_s,
`ifdef UART_RX_PARITY_EN
    PARITY_s,
`endif
    STOP_s
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [COMP_W-1:0]      comp_c, comp_int, comp_eff, comp_half, comp_last;
  logic [3:0]             bit_c, stop_last;
  logic [1:0]             stop_sel_int;
  logic [7:0]             shift_reg;
  logic                   stop_ok, stop_all, tick, stop_done, par_bad, good;

  assign rx_s      = sync[SYNC_STAGES-1];
  assign comp_eff  = (comp_int < COMP_W'(4)) ? COMP_W'(4) : comp_int;
  assign comp_half = comp_eff >> 1;
  assign comp_last = comp_eff - COMP_W'(1);
  assign tick      = (comp_c == comp_last);
  assign stop_last = stop_sel_int[1] ? 4'd1 : 4'd0;
  assign stop_all  = stop_ok & rx_s;
  assign good      = stop_done & stop_all & ~par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_en_int, par_odd_int, par_bit;
  // Even parity: data XOR parity bit is 0; odd parity: it is 1.
  assign par_bad = par_en_int & ((^shift_reg) ^ par_bit ^ par_odd_int);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE_s;
      sync  <= '1;
    end else begin
      state <= state_n;
      sync  <= {sync[SYNC_STAGES-2:0], uart_rx};
    end
  end

  always_comb begin
    state_n   = state;
    stop_done = 1'b0;
    case (state)
      IDLE_s:    if (!rx_s) state_n = START_s;
      START_s:   if (comp_c == comp_half) state_n = rx_s ? IDLE_s : RECEIVE_s;
      RECEIVE_s: if (tick && bit_c == 4'd7) begin
`ifdef UART_RX_PARITY_EN
        state_n = par_en_int ? PARITY_s : STOP_s;
`else
        state_n = STOP_s;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY_s:  if (tick) state_n = STOP_s;
`endif
      STOP_s:    if (tick && bit_c == stop_last) begin
        state_n   = IDLE_s;
        stop_done = 1'b1;
      end
      default:   state_n = IDLE_s;
    endcase
    if (!rec_en) begin
      state_n   = IDLE_s;
      stop_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      comp_c       <= '0;
      bit_c        <= '0;
      comp_int     <= '0;
      stop_sel_int <= '0;
      shift_reg    <= '0;
      stop_ok      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_en_int   <= 1'b0;
      par_odd_int  <= 1'b0;
      par_bit      <= 1'b0;
`endif
    end else if (!rec_en) begin
      comp_c <= '0;
      bit_c  <= '0;
    end else begin
      case (state)
        IDLE_s: begin
          comp_c <= '0;
          bit_c  <= '0;
          if (!rx_s) begin
            comp_int     <= comp;
            stop_sel_int <= stop_sel;
`ifdef UART_RX_PARITY_EN
            par_en_int   <= par_en;
            par_odd_int  <= par_odd;
`endif
          end
        end
        START_s: begin
          stop_ok <= 1'b1;
          bit_c   <= '0;
          comp_c  <= (comp_c == comp_half) ? '0 : comp_c + COMP_W'(1);
        end
        RECEIVE_s: begin
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            comp_c    <= '0;
            bit_c     <= (bit_c == 4'd7) ? 4'd0 : bit_c + 4'd1;
          end else begin
            comp_c <= comp_c + COMP_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY_s: begin
          if (tick) begin
            par_bit <= rx_s;
            comp_c  <= '0;
          end else begin
            comp_c <= comp_c + COMP_W'(1);
          end
        end
`endif
        STOP_s: begin
          if (tick) begin
            stop_ok <= stop_all;
            comp_c  <= '0;
            bit_c   <= stop_done ? 4'd0 : bit_c + 4'd1;
          end else begin
            comp_c <= comp_c + COMP_W'(1);
          end
        end
        default: comp_c <= '0;
      endcase
    end
  end

  // Completion is decided on the edge of the last stop sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_ack) rx_valid <= 1'b0;
      if (stop_done && !stop_all) begin
        frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
      end else if (stop_done && par_bad) begin
        parity_err <= 1'b1;
`endif
      end else if (good) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver : directed scoreboard bench for uart_receiver (default build).
module tb_uart_receiver;

  localparam int COMP_W = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rec_en;
  logic [COMP_W-1:0] comp;
  logic [1:0]        stop_sel;
  logic              uart_rx;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              frame_err;
  logic              overrun_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int frame_cnt = 0;
  int ovr_cnt = 0;
  logic valid_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_receiver #(.COMP_W(COMP_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .rec_en(rec_en), .comp(comp),
    .stop_sel(stop_sel), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .frame_err(frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops one expected byte at each rising edge of rx_valid.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (rx_valid && !valid_q) begin
        rises++;
        rise_cyc = cyc;
        if (exp_q.size() == 0) check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) begin
        frame_cnt++;
        check("flag_excl", {31'd0, overrun_err}, 32'd0);
      end
      if (overrun_err) ovr_cnt++;
    end
    valid_q = rx_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int bitlen, input int nstop, input logic last_stop);
    fall_cyc = cyc;
    uart_rx = 1'b0;
    clks(bitlen);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      clks(bitlen);
    end
    for (int s = 0; s < nstop; s++) begin
      uart_rx = (s == nstop - 1) ? last_stop : 1'b1;
      clks(bitlen);
    end
    uart_rx = 1'b1;
    clks(bitlen * 2);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    int r0, f0, o0, lat;
    resetn = 1'b0; rec_en = 1'b1; comp = 16'd16; stop_sel = 2'b00;
    uart_rx = 1'b1; rx_ack = 1'b0;
    clks(4);
    @(negedge clk);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun_err", {31'd0, overrun_err}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    clks(5);

    // Basic byte with latency
    exp_q.push_back(8'hA5);
    send(8'hA5, 16, 1, 1'b1);
    lat = rise_cyc - fall_cyc;
    check("latency_in_range", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    @(negedge clk);
    check("valid_held", {31'd0, rx_valid}, 32'd1);
    ack();
    @(negedge clk);
    check("valid_cleared", {31'd0, rx_valid}, 32'd0);

    // Short glitch is a false start
    r0 = rises; f0 = frame_cnt; o0 = ovr_cnt;
    @(posedge clk); #1;
    uart_rx = 1'b0; clks(5); uart_rx = 1'b1; clks(60);
    check("glitch_no_valid", rises, r0);
    check("glitch_no_frame", frame_cnt, f0);
    check("glitch_no_overrun", ovr_cnt, o0);

    // Two stop bits, second low
    stop_sel = 2'b10;
    clks(2);
    r0 = rises; f0 = frame_cnt;
    send(8'h3C, 16, 2, 1'b0);
    check("frame_err_pulse", frame_cnt, f0 + 1);
    check("frame_no_valid", rises, r0);
    @(negedge clk);
    check("frame_rx_valid", {31'd0, rx_valid}, 32'd0);
    stop_sel = 2'b00;
    clks(2);

    // Overrun: second byte arrives before ack
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send(8'h11, 16, 1, 1'b1);
    send(8'h22, 16, 1, 1'b1);
    check("overrun_pulse", ovr_cnt, o0 + 1);
    @(negedge clk);
    check("overrun_data_kept", {24'd0, rx_data}, 32'h11);
    check("overrun_valid_kept", {31'd0, rx_valid}, 32'd1);
    ack();
    @(negedge clk);
    check("overrun_ack_clears", {31'd0, rx_valid}, 32'd0);

    // rec_en drop during bit 4 of 0xFF aborts the frame
    r0 = rises;
    @(posedge clk); #1;
    uart_rx = 1'b0; clks(16);
    uart_rx = 1'b1; clks(64 + 5);
    rec_en = 1'b0; clks(3);
    rec_en = 1'b1; clks(8 + 16 * 6);
    exp_q.push_back(8'h5A);
    send(8'h5A, 16, 1, 1'b1);
    check("rec_en_single_delivery", rises, r0 + 1);
    ack();

    // comp below 4 is clamped to 4 clocks per bit
    comp = 16'd3;
    clks(2);
    exp_q.push_back(8'hC3);
    send(8'hC3, 4, 1, 1'b1);
    ack();
    clks(10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
